// File: rtl/alu_share_arbiter.sv
// Shares one combinational 16-bit ALU among NUM_REQ requesters: round-robin grant, registered
// ALU drive, captured result on a valid/ready response. Define ALU_FIXED_PRIO_EN for fixed priority.
module alu_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      reqValid,
  output logic [NUM_REQ-1:0]      reqReady,
  input  logic [2*NUM_REQ-1:0]    reqOp,
  input  logic [16*NUM_REQ-1:0]   reqA,
  input  logic [16*NUM_REQ-1:0]   reqB,
  output logic [1:0]              aluSelect,
  output logic [15:0]             aluIn1,
  output logic [15:0]             aluIn2,
  input  logic [15:0]             aluOut,
  output logic                    respValid,
  input  logic                    respReady,
  output logic [15:0]             respData,
  output logic [ID_WIDTH-1:0]     respId,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_next;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] win;
  logic                any_valid;
  logic [1:0]          sel_op;
  logic [15:0]         sel_a;
  logic [15:0]         sel_b;

  assign any_valid = |reqValid;

`ifdef ALU_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--)
      if (reqValid[i-1]) win = ID_WIDTH'(i - 1);
  end
`else
  logic [ID_WIDTH-1:0] last_grant;
  logic                found_hi;

  // Descending scan: lowest valid index above last_grant wins, else wrap to lowest valid index.
  always_comb begin
    win      = '0;
    found_hi = 1'b0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (reqValid[i-1]) begin
        if (ID_WIDTH'(i - 1) > last_grant) begin
          win      = ID_WIDTH'(i - 1);
          found_hi = 1'b1;
        end else if (!found_hi) begin
          win = ID_WIDTH'(i - 1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    else if (state == RESP && respReady)
      last_grant <= grant;
  end
`endif

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == ID_WIDTH'(i)) begin
        sel_op = reqOp[2*i +: 2];
        sel_a  = reqA[16*i +: 16];
        sel_b  = reqB[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    reqReady   = '0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = ISSUE;
          for (int unsigned i = 0; i < NUM_REQ; i++)
            reqReady[i] = (win == ID_WIDTH'(i));
        end
      end
      ISSUE: begin
        busy       = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (respReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluSelect <= '0;
      aluIn1    <= '0;
      aluIn2    <= '0;
      grant     <= '0;
      respValid <= 1'b0;
      respData  <= '0;
      respId    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            aluSelect <= sel_op;
            aluIn1    <= sel_a;
            aluIn2    <= sel_b;
            grant     <= win;
          end
        end
        ISSUE: begin
          respData  <= aluOut;
          respId    <= grant;
          respValid <= 1'b1;
        end
        RESP: begin
          if (respReady) respValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed results. Honours ALU_FIXED_PRIO_EN.
module tb_alu_share_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int ID_WIDTH = 2;

  logic                  clock;
  logic                  reset;
  logic [NUM_REQ-1:0]    reqValid;
  logic [NUM_REQ-1:0]    reqReady;
  logic [2*NUM_REQ-1:0]  reqOp;
  logic [16*NUM_REQ-1:0] reqA;
  logic [16*NUM_REQ-1:0] reqB;
  logic [1:0]            aluSelect;
  logic [15:0]           aluIn1;
  logic [15:0]           aluIn2;
  logic [15:0]           aluOut;
  logic                  respValid;
  logic                  respReady;
  logic [15:0]           respData;
  logic [ID_WIDTH-1:0]   respId;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqA(reqA), .reqB(reqB), .aluSelect(aluSelect),
    .aluIn1(aluIn1), .aluIn2(aluIn2), .aluOut(aluOut), .respValid(respValid),
    .respReady(respReady), .respData(respData), .respId(respId), .busy(busy)
  );

  function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      2'b01:   return a | b;
      2'b10:   return a & b;
      2'b11:   return a + b;
      default: return 16'h0000;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  assign aluOut = alu_ref(aluSelect, aluIn1, aluIn2);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
`ifdef ALU_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  // Reference model: at most one transaction in flight; m_age counts edges since its grant.
  bit          m_busy;
  int          m_age, m_id, m_last;
  logic [1:0]  m_op;
  logic [15:0] m_a, m_b, m_res;

  always @(negedge clock) begin
    int w;
    logic [NUM_REQ-1:0] exp_ready;
    if (reset) begin
      m_busy = 0; m_age = 0; m_last = NUM_REQ - 1;
      chk("rst_respValid", respValid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reqReady", reqReady, 0);
      chk("rst_aluSelect", aluSelect, 0);
      chk("rst_aluIn", {aluIn1, aluIn2}, 0);
      chk("rst_resp", {respData, 14'd0, respId}, 0);
    end else begin
      w = -1;
      exp_ready = '0;
      if (!m_busy && reqValid != '0) begin
        w = pick(reqValid, m_last);
        exp_ready[w] = 1'b1;
      end
      chk("reqReady", reqReady, exp_ready);
      chk("busy", busy, m_busy);
      chk("respValid", respValid, m_busy && m_age >= 2);
      if (m_busy) begin
        chk("aluSelect", aluSelect, m_op);
        chk("aluIn1", aluIn1, m_a);
        chk("aluIn2", aluIn2, m_b);
      end
      if (m_busy && m_age >= 2) begin
        chk("respData", respData, m_res);
        chk("respId", respId, m_id);
      end
      if (w >= 0) begin
        m_busy = 1; m_age = 1; m_id = w;
        m_op = reqOp[2*w +: 2];
        m_a  = reqA[16*w +: 16];
        m_b  = reqB[16*w +: 16];
        m_res = alu_ref(m_op, m_a, m_b);
      end else if (m_busy) begin
        if (m_age >= 2 && respReady) begin
          m_busy = 0;
          m_last = m_id;
        end else if (m_age < 2) begin
          m_age++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    reqOp[2*i +: 2]  = op;
    reqA[16*i +: 16] = a;
    reqB[16*i +: 16] = b;
  endtask

  task automatic wait_grant(input int idx, input string name);
    bit got;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (reqReady[idx]) got = 1;
    end
    if (!got) note_timeout(name);
  endtask

  task automatic wait_resp(input logic [15:0] exp_data, input int exp_id, input string name);
    bit got;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (respValid) got = 1;
    end
    if (!got) note_timeout(name);
    else begin
      chk({name, "_data"}, respData, exp_data);
      chk({name, "_id"}, respId, exp_id);
    end
  endtask

  logic [1:0]  w_op  [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
  logic [15:0] w_a   [4] = '{16'hFFFF, 16'hF0F0, 16'hF0F0, 16'hF0F0};
  logic [15:0] w_b   [4] = '{16'h0002, 16'h0F00, 16'h0F00, 16'h0F00};
  logic [15:0] w_exp [4] = '{16'h0001, 16'hFFF0, 16'h0000, 16'h0000};
`ifdef ALU_FIXED_PRIO_EN
  int rr_exp [6] = '{0, 0, 0, 0, 0, 0};
  localparam logic [3:0] BP_NEXT = 4'b0010;
`else
  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
  localparam logic [3:0] BP_NEXT = 4'b1000;
`endif

  initial begin
    int lat, cyc, ng, nr;
    int gcyc [8];
    int ids  [6];
    bit got;
    logic [15:0] held_data;

    reset = 1'b1; reqValid = '0; reqOp = '0; reqA = '0; reqB = '0; respReady = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Single request from requester 2: 00FF + 0001, two edges from grant to respValid.
    step();
    set_req(2, 2'b11, 16'h00FF, 16'h0001);
    reqValid[2] = 1'b1;
    respReady = 1'b1;
    wait_grant(2, "single_grant");
    step();
    reqValid[2] = 1'b0;
    lat = 0; got = 0;
    for (int n = 1; n <= 10 && !got; n++) begin
      @(negedge clock);
      if (respValid) begin got = 1; lat = n; end
    end
    if (!got) note_timeout("single_resp");
    else begin
      chk("single_latency", lat, 2);
      chk("single_data", respData, 16'h0100);
      chk("single_id", respId, 2);
    end

    // Opcode / wrap-around vectors on requester 0.
    for (int t = 0; t < 4; t++) begin
      step();
      set_req(0, w_op[t], w_a[t], w_b[t]);
      reqValid[0] = 1'b1;
      wait_grant(0, "wrap_grant");
      step();
      reqValid[0] = 1'b0;
      wait_resp(w_exp[t], 0, "wrap");
    end

    // Fairness with all requesters continuously valid.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b11, 16'h1000 * (i + 1), 16'(i));
    reqValid = '1;
    respReady = 1'b1;
    cyc = 0; ng = 0; nr = 0;
    while (nr < 6 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (reqReady != '0 && ng < 8) begin gcyc[ng] = cyc; ng++; end
      if (respValid && respReady) begin ids[nr] = respId; nr++; end
    end
    if (nr < 6 || ng < 6) note_timeout("rr_sequence");
    else begin
      for (int i = 0; i < 6; i++) chk($sformatf("rr_id%0d", i), ids[i], rr_exp[i]);
      for (int i = 1; i < 6; i++) chk($sformatf("rr_interval%0d", i), gcyc[i] - gcyc[i-1], 3);
    end
    step();
    reqValid = '0;
    repeat (4) step();

    // Backpressure: response held for 5 cycles, then the next grant lands in the next IDLE cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    respReady = 1'b0;
    set_req(1, 2'b01, 16'h1200, 16'h0034);
    set_req(3, 2'b11, 16'h0001, 16'h0001);
    reqValid = 4'b1010;
    wait_resp(16'h1234, 1, "bp_first");
    held_data = respData;
    repeat (5) begin
      @(negedge clock);
      chk("bp_hold_data", respData, 16'h1234);
      chk("bp_hold_id", respId, 1);
      chk("bp_reqReady", reqReady, 4'b0000);
      chk("bp_busy", busy, 1);
    end
    step();
    respReady = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("bp_next_grant", reqReady, BP_NEXT);
    step();
    reqValid = '0;
    repeat (6) step();

    // Reset while the operation is in ISSUE: outputs clear at once, nothing is emitted.
    set_req(2, 2'b10, 16'hFF00, 16'h0FF0);
    reqValid = 4'b0100;
    wait_grant(2, "midop_grant");
    step();
    reqValid = '0;
    #1 reset = 1'b1;
    #1;
    chk("midop_respValid", respValid, 0);
    chk("midop_aluSelect", aluSelect, 2'b00);
    chk("midop_busy", busy, 0);
    repeat (2) @(negedge clock);
    step();
    reset = 1'b0;
    reqValid = '1;
    @(negedge clock);
    chk("midop_first_grant", reqReady, 4'b0001);
    step();
    reqValid = '0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
